m21_rr_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer for the 2:1 mux. Two requesters share one output channel.

---
 rtl/m21_rr_arbiter.sv | 122 ++++++++++++
 tb/tb_m21_rr_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/m21_rr_arbiter.sv
// Round-robin arbiter for two requesters sharing one registered valid/ready output stage.
// Drives the 2:1 mux select and caps each grant at MAX_BURST words while the other side waits.
//
// state | meaning
// IDLE  | no grant; arbitration bubble before the next grant
// GNT0  | requester 0 owns the output channel, sel=0
// GNT1  | requester 1 owns the output channel, sel=1
module m21_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    state_t     state;
    state_t     state_nxt;
    logic       last_grant;
    logic [3:0] burst_cnt;
    logic       can_accept;
    logic       accept;
    logic       burst_done;
    logic       grant_entry;

    assign can_accept  = !out_valid || out_ready;
    assign accept      = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign burst_done  = accept && (burst_cnt == BURST_LAST);
    assign grant_entry = (state_nxt != state) && (state_nxt != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            burst_cnt  <= 4'd0;
            sel        <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant_entry) begin
                last_grant <= (state_nxt == GNT1);
                sel        <= (state_nxt == GNT1);
                burst_cnt  <= 4'd0;
            end else if (burst_done) begin
                // sole requester: start a fresh burst without leaving the grant
                burst_cnt <= 4'd0;
            end else if (accept) begin
                burst_cnt <= burst_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    state_nxt = last_grant ? GNT0 : GNT1;
                end else if (req0_valid) begin
                    state_nxt = GNT0;
                end else if (req1_valid) begin
                    state_nxt = GNT1;
                end
            end
            GNT0: begin
                if (burst_done || !req0_valid) begin
                    if (req1_valid) begin
                        state_nxt = GNT1;
                    end else if (!burst_done) begin
                        state_nxt = IDLE;
                    end
                end
            end
            GNT1: begin
                if (burst_done || !req1_valid) begin
                    if (req0_valid) begin
                        state_nxt = GNT0;
                    end else if (!burst_done) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = (state == GNT0) && can_accept;
        req1_ready = (state == GNT1) && can_accept;
        busy       = (state != IDLE) || out_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sel ? req1_data : req0_data;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_m21_rr_arbiter.sv
// Directed self-checking bench for m21_rr_arbiter (WIDTH=8, MAX_BURST=4).
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_m21_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       sel;
    logic       busy;

    int errors = 0;
    int checks = 0;

    m21_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .sel        (sel),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        logic [7:0] prev;
        int         n0;
        int         n1;
        int         g;

        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = 8'h00; req1_data = 8'h00;
        out_ready = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;

        // single source on req0: bubble, then one word per cycle
        cyc(); req0_valid = 1'b1; req0_data = 8'h11; out_ready = 1'b1; settle();
        chk("t2_idle_ready0", req0_ready, 1'b0);
        chk("t2_idle_ovalid", out_valid, 1'b0);
        chk("t2_idle_sel", sel, 1'b0);
        chk("t2_idle_busy", busy, 1'b0);
        cyc(); settle();
        chk("t2_gnt_ready0", req0_ready, 1'b1);
        chk("t2_gnt_ready1", req1_ready, 1'b0);
        chk("t2_gnt_sel", sel, 1'b0);
        chk("t2_gnt_busy", busy, 1'b1);
        cyc(); req0_data = 8'h22; settle();
        chk("t2_w0_valid", out_valid, 1'b1);
        chk("t2_w0_data", out_data, 8'h11);
        chk("t2_w1_ready", req0_ready, 1'b1);
        cyc(); req0_data = 8'h33; settle();
        chk("t2_w1_data", out_data, 8'h22);
        chk("t2_w2_ready", req0_ready, 1'b1);
        cyc(); req0_valid = 1'b0; settle();
        chk("t2_w2_data", out_data, 8'h33);
        chk("t2_w2_valid", out_valid, 1'b1);
        cyc(); settle();
        chk("t2_end_valid", out_valid, 1'b0);
        chk("t2_end_busy", busy, 1'b0);
        chk("t2_end_ready0", req0_ready, 1'b0);

        // backpressure: 0xA5 held for three stalled cycles, then 0xB6 follows
        cyc(); req0_valid = 1'b1; req0_data = 8'hA5; out_ready = 1'b0; settle();
        chk("t4_idle_busy", busy, 1'b0);
        cyc(); settle();
        chk("t4_gnt_ready0", req0_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(); req0_data = 8'hB6; settle();
            chk("t4_stall_valid", out_valid, 1'b1);
            chk("t4_stall_data", out_data, 8'hA5);
            chk("t4_stall_ready0", req0_ready, 1'b0);
            chk("t4_stall_ready1", req1_ready, 1'b0);
        end
        cyc(); out_ready = 1'b1; settle();
        chk("t4_resume_ready0", req0_ready, 1'b1);
        chk("t4_resume_data", out_data, 8'hA5);
        cyc(); req0_valid = 1'b0; settle();
        chk("t4_next_data", out_data, 8'hB6);
        chk("t4_next_valid", out_valid, 1'b1);
        cyc(); settle();
        chk("t4_drain_valid", out_valid, 1'b0);
        chk("t4_drain_busy", busy, 1'b0);

        // source drop on req1 after two words; busy held by the stalled last word
        cyc(); req1_valid = 1'b1; req1_data = 8'h51; settle();
        chk("t5_idle_sel", sel, 1'b0);
        cyc(); settle();
        chk("t5_gnt_sel", sel, 1'b1);
        chk("t5_gnt_ready1", req1_ready, 1'b1);
        chk("t5_gnt_ready0", req0_ready, 1'b0);
        cyc(); req1_data = 8'h52; settle();
        chk("t5_w0_data", out_data, 8'h51);
        cyc(); req1_valid = 1'b0; out_ready = 1'b0; settle();
        chk("t5_w1_data", out_data, 8'h52);
        chk("t5_w1_busy", busy, 1'b1);
        cyc(); out_ready = 1'b1; settle();
        chk("t5_idle_ready1", req1_ready, 1'b0);
        chk("t5_held_busy", busy, 1'b1);
        chk("t5_held_data", out_data, 8'h52);
        chk("t5_held_sel", sel, 1'b1);
        cyc(); settle();
        chk("t5_end_busy", busy, 1'b0);
        chk("t5_end_sel", sel, 1'b1);

        // req1 alone for 10 words across burst boundaries: no bubble
        cyc(); req1_valid = 1'b1; req1_data = 8'h60; settle();
        chk("t6_idle_ready1", req1_ready, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(); req1_data = 8'(8'h60 + i); settle();
            chk("t6_ready1", req1_ready, 1'b1);
            chk("t6_sel", sel, 1'b1);
            if (i > 0) begin
                prev = 8'(8'h60 + i - 1);
                chk("t6_data", out_data, prev);
                chk("t6_valid", out_valid, 1'b1);
            end
        end

        // asynchronous reset mid-burst with a word pending
        cyc(); settle();
        chk("t1_pre_valid", out_valid, 1'b1);
        chk("t1_pre_data", out_data, 8'h69);
        rst_n = 1'b0; settle();
        chk("t1_rst_valid", out_valid, 1'b0);
        chk("t1_rst_data", out_data, 8'h00);
        chk("t1_rst_sel", sel, 1'b0);
        chk("t1_rst_busy", busy, 1'b0);
        chk("t1_rst_ready0", req0_ready, 1'b0);
        chk("t1_rst_ready1", req1_ready, 1'b0);

        // tie from reset: req0 first, bursts of 4 alternate with no bubble
        req0_valid = 1'b1; req0_data = 8'h01;
        req1_valid = 1'b1; req1_data = 8'h81;
        cyc(); cyc(); rst_n = 1'b1; settle();
        chk("t3_idle_ready0", req0_ready, 1'b0);
        chk("t3_idle_ready1", req1_ready, 1'b0);
        n0 = 0; n1 = 0; prev = 8'h00;
        for (int j = 0; j < 12; j++) begin
            g = (j / 4) % 2;
            cyc();
            req0_data = 8'(8'h01 + n0);
            req1_data = 8'(8'h81 + n1);
            settle();
            chk("t3_sel", sel, g[0]);
            chk("t3_ready0", req0_ready, (g == 0));
            chk("t3_ready1", req1_ready, (g == 1));
            if (j > 0) chk("t3_data", out_data, prev);
            if (g == 0) begin
                prev = 8'(8'h01 + n0);
                n0++;
            end else begin
                prev = 8'(8'h81 + n1);
                n1++;
            end
        end
        cyc(); req0_valid = 1'b0; req1_valid = 1'b0; settle();
        chk("t3_last_data", out_data, 8'h08);
        cyc(); cyc(); settle();
        chk("t3_end_busy", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
